// File: rtl/trace_pkg.sv
// trace_pkg
// Shared types and widths for the commit trace buffer.
//
// Contents:
//   XLEN, REG_IDX_W  : architectural data width and register index width
//   trace_rec_t      : full trace record {pc, rd, data, wb, tstamp}
//   trace_core_t     : the same record without the cycle stamp, stored
//                      when TRACE_TIMESTAMP_EN is not defined
//   make_core_rec()  : builds a record and folds writes to x0 into non-writes
//
// The stamp field is named tstamp because "time" is a reserved word.
package trace_pkg;

  localparam int XLEN      = 32;
  localparam int REG_IDX_W = 5;

  typedef struct packed {
    logic [XLEN-1:0]      pc;
    logic [REG_IDX_W-1:0] rd;
    logic [XLEN-1:0]      data;
    logic                 wb;
    logic [XLEN-1:0]      tstamp;
  } trace_rec_t;

  typedef struct packed {
    logic [XLEN-1:0]      pc;
    logic [REG_IDX_W-1:0] rd;
    logic [XLEN-1:0]      data;
    logic                 wb;
  } trace_core_t;

  // A write to x0 has no architectural effect, so it is logged as a
  // non-write with rd and data cleared.
  function automatic trace_core_t make_core_rec(
    input logic [XLEN-1:0]      pc,
    input logic                 wb_en,
    input logic [REG_IDX_W-1:0] rd,
    input logic [XLEN-1:0]      data
  );
    trace_core_t r;
    logic        wb_eff;
    wb_eff = wb_en && (rd != '0);
    r.pc   = pc;
    r.wb   = wb_eff;
    r.rd   = wb_eff ? rd : '0;
    r.data = wb_eff ? data : '0;
    return r;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// trace_fifo
// Generic first-word-fall-through FIFO. data_o always shows the head entry
// and reads as all-zero while the FIFO is empty.
//
// Parameters:
//   DEPTH : number of entries, power of two (2..64)
//   T     : element type
// Ports:
//   clk_i   : clock, all state updates on the rising edge
//   rst_i   : synchronous active-high reset, empties the FIFO
//   push_i  : write data_i; accepted when not full or when popping the
//             same cycle
//   data_i  : element to write
//   pop_i   : remove the head entry; ignored while empty
//   data_o  : head entry
//   full_o  : all DEPTH entries held
//   empty_o : no entries held
//   count_o : number of entries held
module trace_fifo #(
  parameter int  DEPTH = 8,
  parameter type T     = logic [7:0]
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  T                       data_i,
  input  logic                   pop_i,
  output T                       data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int                AW      = $clog2(DEPTH);
  localparam logic [AW:0]       FullCnt = (AW+1)'(DEPTH);
  localparam logic [AW:0]       CntOne  = (AW+1)'(1);
  localparam logic [AW-1:0]     PtrOne  = AW'(1);

  T              mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_ok, pop_ok;

  assign full_o  = (count_q == FullCnt);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  // A pop in the same cycle frees the slot, so a push into a full FIFO is
  // still accepted when paired with a pop.
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  // Stale memory contents are masked so the head reads zero while empty.
  assign data_o = empty_o ? T'('0) : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PtrOne;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrOne;
    if (push_ok && !pop_ok)      count_d = count_q + CntOne;
    else if (pop_ok && !push_ok) count_d = count_q - CntOne;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage has no reset; entries are only visible once written.
  always_ff @(posedge clk_i) begin
    if (push_ok && !rst_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/commit_trace_buffer.sv
// commit_trace_buffer
// Captures one record per retired instruction (PC, rd, write data) into a
// FWFT FIFO that drains through a valid/ready port. Records arriving while
// the FIFO is full and not being drained are dropped and counted.
//
// Optional feature macro: TRACE_TIMESTAMP_EN
//   defined   : a free-running 32-bit cycle counter is stored per record and
//               shown on trace_time
//   undefined : no counter or per-entry stamp storage; trace_time is 0
//
// Parameters: DEPTH (FIFO entries, power of two 2..64), CNT_W (drop counter)
// Ports:
//   clk, rst                           : clock, synchronous active-high reset
//   commit_valid, commit_pc            : retiring instruction and its PC
//   wb_en, wb_rd, wb_data              : register-file write of that instr.
//   trace_valid, trace_ready           : head record handshake
//   trace_pc/rd/data/wb/time           : head record fields
//   occupancy                          : entries held
//   overflow                           : sticky, a record was dropped
//   drop_cnt                           : dropped records, saturating
module commit_trace_buffer
  import trace_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   commit_valid,
  input  logic [XLEN-1:0]        commit_pc,
  input  logic                   wb_en,
  input  logic [REG_IDX_W-1:0]   wb_rd,
  input  logic [XLEN-1:0]        wb_data,
  output logic                   trace_valid,
  input  logic                   trace_ready,
  output logic [XLEN-1:0]        trace_pc,
  output logic [REG_IDX_W-1:0]   trace_rd,
  output logic [XLEN-1:0]        trace_data,
  output logic                   trace_wb,
  output logic [XLEN-1:0]        trace_time,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic                   overflow,
  output logic [CNT_W-1:0]       drop_cnt
);

`ifdef TRACE_TIMESTAMP_EN
  typedef trace_rec_t store_t;
`else
  typedef trace_core_t store_t;
`endif

  localparam logic [CNT_W-1:0] DropOne = CNT_W'(1);

  store_t           wr_rec, head_rec;
  trace_core_t      core_rec;
  logic             fifo_full, fifo_empty;
  logic             push, pop, drop;
  logic             overflow_q, overflow_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  assign pop  = !fifo_empty && trace_ready;
  assign push = commit_valid && (!fifo_full || pop);
  assign drop = commit_valid && fifo_full && !pop;

`ifdef TRACE_TIMESTAMP_EN
  logic [XLEN-1:0] cycle_q;

  // Free-running stamp; the value in the push cycle is stored with the record.
  always_ff @(posedge clk) begin
    if (rst) cycle_q <= '0;
    else     cycle_q <= cycle_q + XLEN'(1);
  end
`endif

  always_comb begin
    core_rec = make_core_rec(commit_pc, wb_en, wb_rd, wb_data);
    wr_rec   = '0;
    wr_rec.pc   = core_rec.pc;
    wr_rec.rd   = core_rec.rd;
    wr_rec.data = core_rec.data;
    wr_rec.wb   = core_rec.wb;
`ifdef TRACE_TIMESTAMP_EN
    wr_rec.tstamp = cycle_q;
`endif
  end

  trace_fifo #(
    .DEPTH (DEPTH),
    .T     (store_t)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (push),
    .data_i  (wr_rec),
    .pop_i   (pop),
    .data_o  (head_rec),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (occupancy)
  );

  assign trace_valid = !fifo_empty;
  assign trace_pc    = head_rec.pc;
  assign trace_rd    = head_rec.rd;
  assign trace_data  = head_rec.data;
  assign trace_wb    = head_rec.wb;
`ifdef TRACE_TIMESTAMP_EN
  assign trace_time  = head_rec.tstamp;
`else
  assign trace_time  = '0;
`endif

  // Drop accounting: the counter saturates and overflow stays set until reset.
  always_comb begin
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + DropOne;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;

endmodule
